ntt_layer_sequencer: RTL and testbench

//  Sequences one shared Kyber butterfly unit through a full 256-point NTT (CT mode) or

---
 rtl/ntt_layer_sequencer_if.sv | 37 +++
 rtl/ntt_layer_sequencer.sv | 156 +++++++++++++++
 tb/tb_ntt_layer_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_layer_sequencer_if.sv
// Bus between the NTT layer sequencer and its RAM/ROM/butterfly environment.
// The stall input exists only when NTT_SEQ_STALL_EN is defined.
interface ntt_layer_sequencer_if;
    logic       start;
    logic       inv;
`ifdef NTT_SEQ_STALL_EN
    logic       stall;
`endif
    logic       ct;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_addr;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
    logic       busy;
    logic       done;

    modport master (
        output ct, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b, busy, done,
        input  start, inv
`ifdef NTT_SEQ_STALL_EN
        , input stall
`endif
    );

    modport slave (
        input  ct, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b, busy, done,
        output start, inv
`ifdef NTT_SEQ_STALL_EN
        , output stall
`endif
    );
endinterface

// File: rtl/ntt_layer_sequencer.sv
// Drives one shared Kyber butterfly through 7 layers x 128 butterflies (NTT or INTT).
// Optional issue stall is compiled in with NTT_SEQ_STALL_EN.
module ntt_layer_sequencer #(
    parameter int BF_LAT  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    ntt_layer_sequencer_if.master        bus
);
    localparam int D  = MEM_LAT + BF_LAT;
    localparam int DW = $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t          state;
    logic [2:0]      layer;
    logic [6:0]      cnt;
    logic [DW-1:0]   dcnt;
    logic            ct;
    logic            rd_en;
    logic [7:0]      rd_addr_a;
    logic [7:0]      rd_addr_b;
    logic [6:0]      tw_addr;
    logic            busy;
    logic            done;
    logic            stall;

    logic [D-1:0]    vld_p;
    logic [7:0]      addr_a_p [D];
    logic [7:0]      addr_b_p [D];

`ifdef NTT_SEQ_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    // {a, b, tw} for butterfly idx of layer lyr; len halves per layer in CT, doubles in GS
    function automatic logic [22:0] pair_addr(input logic intt, input logic [2:0] lyr,
                                              input logic [6:0] idx);
        logic [2:0] sh;
        logic [7:0] len;
        logic [6:0] msk;
        logic [6:0] g;
        logic [6:0] j;
        logic [6:0] tw;
        logic [7:0] a;
        sh  = intt ? lyr + 3'd1 : 3'd7 - lyr;
        len = 8'd1 << sh;
        msk = len[6:0] - 7'd1;
        g   = idx >> sh;
        j   = idx & msk;
        a   = ({1'b0, g} << ({1'b0, sh} + 4'd1)) + {1'b0, j};
        tw  = intt ? (7'h7f >> lyr) - g : (7'd1 << lyr) + g;
        return {a, a + len, tw};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            layer     <= '0;
            cnt       <= '0;
            dcnt      <= '0;
            ct        <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ISSUE;
                        layer <= '0;
                        cnt   <= '0;
                        ct    <= ~bus.inv;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_addr} <= pair_addr(bus.inv, 3'd0, 7'd0);
                    end
                end
                // cnt is the butterfly currently on the read bus; advance only when not stalled
                ISSUE: begin
                    if (stall) begin
                        rd_en <= 1'b0;
                    end else if (cnt == 7'd127) begin
                        rd_en <= 1'b0;
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt   <= cnt + 7'd1;
                        rd_en <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_addr} <= pair_addr(~ct, layer, cnt + 7'd1);
                    end
                end
                // Let the last writes of this layer land before the next layer reads
                DRAIN: begin
                    if (dcnt == DW'(D - 1)) begin
                        if (layer == 3'd6) begin
                            state <= FINISH;
                        end else begin
                            layer <= layer + 3'd1;
                            cnt   <= '0;
                            rd_en <= 1'b1;
                            state <= ISSUE;
                            {rd_addr_a, rd_addr_b, tw_addr} <= pair_addr(~ct, layer + 3'd1, 7'd0);
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-to-write delay line: RAM read latency plus butterfly latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < D; i++) begin
                addr_a_p[i] <= '0;
                addr_b_p[i] <= '0;
            end
        end else begin
            vld_p[0]    <= rd_en;
            addr_a_p[0] <= rd_addr_a;
            addr_b_p[0] <= rd_addr_b;
            for (int i = 1; i < D; i++) begin
                vld_p[i]    <= vld_p[i-1];
                addr_a_p[i] <= addr_a_p[i-1];
                addr_b_p[i] <= addr_b_p[i-1];
            end
        end
    end

    assign bus.ct        = ct;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = rd_addr_a;
    assign bus.rd_addr_b = rd_addr_b;
    assign bus.tw_addr   = tw_addr;
    assign bus.wr_en     = vld_p[D-1];
    assign bus.wr_addr_a = addr_a_p[D-1];
    assign bus.wr_addr_b = addr_b_p[D-1];
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// Scoreboard bench for ntt_layer_sequencer: stimulus queues expectations, a negedge monitor checks them.
// Build with NTT_SEQ_STALL_EN defined to include the stall scenario.
module tb_ntt_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_layer_sequencer_if bus ();
    ntt_layer_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef enum {S_BUSY, S_CT, S_RDEN, S_WREN, S_RDA, S_ALLZ, S_RDCNT, S_WRCNT, S_QEMPTY, S_CLR} sel_t;
    typedef struct { int cyc; sel_t sel; int exp; } chk_t;
    typedef struct { int idx; logic [22:0] v; } spot_t;

    chk_t        chk_q   [$];
    logic [22:0] exp_rd  [$];
    logic [15:0] exp_wr  [$];
    int          exp_done[$];
    int          rdcyc_q [$];
    spot_t       spot_q  [$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd_idx = 0;

    // Monitor: all comparisons happen here
    always @(negedge clk) begin : monitor
        chk_t        c;
        int          act;
        logic [22:0] e;
        logic [15:0] w;
        int          rc;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            act = 0;
            case (c.sel)
                S_BUSY:   act = int'(bus.busy);
                S_CT:     act = int'(bus.ct);
                S_RDEN:   act = int'(bus.rd_en);
                S_WREN:   act = int'(bus.wr_en);
                S_RDA:    act = int'(bus.rd_addr_a);
                S_ALLZ:   act = int'(|{bus.ct, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                                       bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, bus.busy, bus.done});
                S_RDCNT:  act = rd_cnt;
                S_WRCNT:  act = wr_cnt;
                S_QEMPTY: act = exp_rd.size() + exp_wr.size() + exp_done.size() + spot_q.size();
                default:  act = 0;
            endcase
            if (c.sel == S_CLR) begin
                rd_cnt = 0;
                wr_cnt = 0;
                rd_idx = 0;
            end else begin
                checks++;
                if (act != c.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got %0d want %0d", c.sel.name(), cyc, act, c.exp);
                end
            end
        end
        if (bus.rd_en) begin
            rd_cnt++;
            rdcyc_q.push_back(cyc);
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected cyc=%0d got a=%0d b=%0d tw=%0d want no read",
                         cyc, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
            end else begin
                e = exp_rd.pop_front();
                if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} != e) begin
                    errors++;
                    $display("FAIL rd_addr cyc=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             cyc, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, e[22:15], e[14:7], e[6:0]);
                end
            end
            if (spot_q.size() > 0 && spot_q[0].idx == rd_idx) begin
                e = spot_q.pop_front().v;
                checks++;
                if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} != e) begin
                    errors++;
                    $display("FAIL spot_%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d", rd_idx,
                             bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, e[22:15], e[14:7], e[6:0]);
                end
            end
            rd_idx++;
        end
        if (bus.wr_en) begin
            wr_cnt++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected cyc=%0d got a=%0d b=%0d want no write",
                         cyc, bus.wr_addr_a, bus.wr_addr_b);
            end else begin
                w = exp_wr.pop_front();
                if ({bus.wr_addr_a, bus.wr_addr_b} != w) begin
                    errors++;
                    $display("FAIL wr_addr cyc=%0d got a=%0d b=%0d want a=%0d b=%0d",
                             cyc, bus.wr_addr_a, bus.wr_addr_b, w[15:8], w[7:0]);
                end
            end
            if (rdcyc_q.size() > 0) begin
                rc = rdcyc_q.pop_front();
                checks++;
                if (cyc - rc != 5) begin
                    errors++;
                    $display("FAIL wr_latency cyc=%0d got %0d want 5", cyc, cyc - rc);
                end
            end
        end
        if (bus.rd_en && bus.wr_en) begin
            checks++;
            if (bus.wr_addr_a == bus.rd_addr_a || bus.wr_addr_a == bus.rd_addr_b ||
                bus.wr_addr_b == bus.rd_addr_a || bus.wr_addr_b == bus.rd_addr_b) begin
                errors++;
                $display("FAIL rw_hazard cyc=%0d got rd %0d/%0d wr %0d/%0d want disjoint",
                         cyc, bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr_a, bus.wr_addr_b);
            end
        end
        if (bus.done) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got 1 want 0", cyc);
            end else begin
                rc = exp_done.pop_front();
                if (cyc != rc) begin
                    errors++;
                    $display("FAIL done_cycle got %0d want %0d", cyc, rc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int dly, input sel_t s, input int e);
        chk_t c;
        c.cyc = cyc + dly;
        c.sel = s;
        c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic add_spot(input int idx, input int a, input int b, input int tw);
        spot_t s;
        s.idx = idx;
        s.v   = {8'(a), 8'(b), 7'(tw)};
        spot_q.push_back(s);
    endtask

    // Reference loop nest: Kyber zeta counter k walks up (CT) or down (GS) once per group
    task automatic push_model(input bit iv);
        int k;
        int len;
        k = iv ? 127 : 1;
        for (int l = 0; l < 7; l++) begin
            len = iv ? (2 << l) : (128 >> l);
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    exp_rd.push_back({8'(j), 8'(j + len), 7'(k)});
                    exp_wr.push_back({8'(j), 8'(j + len)});
                end
                k = iv ? k - 1 : k + 1;
            end
        end
    endtask

    task automatic start_run(input bit iv, input int extra);
        push_model(iv);
        if (!iv) begin
            add_spot(0,   0,   128, 1);
            add_spot(192, 128, 192, 3);
            add_spot(296, 72,  104, 5);
            add_spot(895, 253, 255, 127);
        end else begin
            add_spot(0,   0, 2,   127);
            add_spot(1,   1, 3,   127);
            add_spot(2,   4, 6,   126);
            add_spot(768, 0, 128, 1);
        end
        expect_at(1, S_CLR, 0);
        expect_at(1, S_BUSY, 1);
        expect_at(1, S_CT, iv ? 0 : 1);
        expect_at(1, S_RDEN, 1);
        exp_done.push_back(cyc + 1 + 932 + extra);
        bus.inv   = iv;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic end_checks(input bit counts);
        if (counts) begin
            expect_at(1, S_RDCNT, 896);
            expect_at(1, S_WRCNT, 896);
        end
        expect_at(1, S_QEMPTY, 0);
        tick(2);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.inv   = 1'b0;
`ifdef NTT_SEQ_STALL_EN
        bus.stall = 1'b0;
`endif
        tick(3);
        expect_at(1, S_ALLZ, 0);
        tick(1);
        rst = 1'b0;
        expect_at(1, S_ALLZ, 0);
        expect_at(1, S_BUSY, 0);
        tick(2);

        // Full forward run
        start_run(1'b0, 0);
        tick(935);
        end_checks(1'b1);

        // Full inverse run
        start_run(1'b1, 0);
        tick(935);
        end_checks(1'b1);

        // Reset during layer 3 issue
        start_run(1'b0, 0);
        tick(419);
        rst = 1'b1;
        expect_at(1, S_ALLZ, 0);
        for (int d = 2; d <= 7; d++) begin
            expect_at(d, S_WREN, 0);
            if (d == 3) expect_at(d, S_BUSY, 0);
        end
        @(posedge clk);
        #1;
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        rdcyc_q.delete();
        spot_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick(8);
        end_checks(1'b0);

        // Start while busy and start in the FINISH cycle are both ignored
        start_run(1'b1, 0);
        tick(199);
        bus.inv   = 1'b0;
        bus.start = 1'b1;
        expect_at(1, S_BUSY, 1);
        expect_at(1, S_CT, 0);
        tick(1);
        bus.start = 1'b0;
        tick(731);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        expect_at(1, S_BUSY, 0);
        expect_at(2, S_BUSY, 0);
        expect_at(2, S_RDEN, 0);
        tick(4);
        end_checks(1'b1);

`ifdef NTT_SEQ_STALL_EN
        // Stall 10 cycles at layer 2, butterfly 40
        start_run(1'b0, 10);
        tick(306);
        bus.stall = 1'b1;
        expect_at(1, S_RDEN, 0);
        expect_at(1, S_WREN, 1);
        expect_at(5, S_RDA, 72);
        expect_at(5, S_WREN, 1);
        expect_at(6, S_WREN, 0);
        tick(10);
        bus.stall = 1'b0;
        tick(630);
        end_checks(1'b1);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
